mem_stage: RTL and testbench

- Memory-access pipeline stage, directly downstream of the execute stage and fed through the EX/MEM buffer.
- Owns the stack pointer (SP) and drives the single-port 16-bit-word data memory.
- Splits 32-bit accesses (PC/flags push/pop, 32-bit load/store) into two sequential word accesses, stalling upstream for one cycle.
- Returns popped flags to the execute-stage CCR and popped PC to fetch.

---
 rtl/mem_stage_if.sv | 20 ++
 rtl/mem_stage.sv | 215 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory port of the memory stage.
// The stage drives address, write data and the two strobes. The memory
// returns read data combinationally in the same cycle.
//   addr   word address (ADDR_W bits)
//   wdata  16-bit write data
//   we     write enable
//   re     read enable
//   rdata  16-bit read data, valid in the cycle addr is presented
interface mem_stage_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic              we;
    logic              re;
    logic [15:0]       rdata;

    modport master (output addr, output wdata, output we, output re, input rdata);
    modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage.
// Owns the stack pointer and drives a single-port 16-bit data memory.
// A 32-bit access (PC/flags push/pop, 32-bit load/store) is split into two
// word accesses. Upstream is stalled during the first word.
// Popped flags go back to execute, and a popped PC goes back to fetch.
//
// Ports:
//   clk, reset            clock and asynchronous active-low reset
//   valid_in .. flags_push_pop_in   operation fields from the EX/MEM buffer
//   dmem                  data-memory port (master side)
//   mem_data_out          loaded value (16-bit loads zero-extended)
//   pop_pc_out/_valid     popped PC {4'b0, loaded[27:0]} and its pulse
//   POP_flags_val_out     popped flags {OVF,Z,N,C}
//   is_POP_flags_out      pulse for the popped flags
//   SP_out                current stack pointer
//   stall_out             upstream must hold EX/MEM contents
//   valid_out             access completes this cycle
//
// state  | meaning
// IDLE   | accepting a new access; 16-bit accesses complete here
// SECOND | second word of a 32-bit access, using registered op fields
//
// The completion outputs are combinational because read data arrives in the
// completing cycle. Only the state, SP and the first-word context are registered.
module mem_stage #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] SP_RESET = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [31:0]       PC_in,
    input  logic [15:0]       Rdst1_val_in,
    input  logic [15:0]       Rsrc_val_in,
    input  logic [15:0]       Rdst_val_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              mem_type_in,
    input  logic              mem_addr_src_in,
    input  logic              mem_data_src_in,
    input  logic [1:0]        SP_src_in,
    input  logic              PC_push_pop_in,
    input  logic              flags_push_pop_in,
    mem_stage_if.master       dmem,
    output logic [31:0]       mem_data_out,
    output logic [31:0]       pop_pc_out,
    output logic              pop_pc_valid,
    output logic [3:0]        POP_flags_val_out,
    output logic              is_POP_flags_out,
    output logic [ADDR_W-1:0] SP_out,
    output logic              stall_out,
    output logic              valid_out
);

    typedef enum logic {IDLE, SECOND} state_t;

    state_t            state;
    logic [ADDR_W-1:0] sp;
    logic [ADDR_W-1:0] addr2_q;
    logic [15:0]       wdata2_q;
    logic [15:0]       low_q;
    logic              rd_q, wr_q, push_q, pop_q, stack_q, pcpp_q, fpp_q;

    logic              access, rd, wr, push, pop;
    logic [ADDR_W-1:0] ea, addr0, addr1;
    logic [15:0]       hi_word, lo_word, wdata0, wdata1;
    logic              cur_rd, cur_pop, cur_pcpp, cur_fpp;
    logic              first_cycle, done_rd;
    logic [31:0]       loaded;

    logic unused_ea_bits;
    assign unused_ea_bits = ^Rdst1_val_in[15:ADDR_W];

    // A read with a simultaneous write is treated as a write.
    assign wr     = mem_write_in;
    assign rd     = mem_read_in & ~mem_write_in;
    assign access = valid_in & (mem_read_in | mem_write_in);
    assign push   = (SP_src_in == 2'd1);
    assign pop    = (SP_src_in == 2'd2);
    assign ea     = Rdst1_val_in[ADDR_W-1:0];

    assign hi_word = mem_data_src_in ? PC_in[31:16] : Rdst_val_in;
    assign lo_word = mem_data_src_in ? PC_in[15:0]  : Rsrc_val_in;

    // Stack pushes store the upper word first, at the higher address.
    // Non-stack stores write the lower word at EA first.
    always_comb begin
        addr0 = ea;
        addr1 = ea + 1'b1;
        if (mem_addr_src_in) begin
            if (push) begin
                addr0 = sp;
                addr1 = sp - 1'b1;
            end else if (pop) begin
                addr0 = sp + 1'b1;
                addr1 = sp + ADDR_W'(2);
            end else begin
                addr0 = sp;
                addr1 = sp + 1'b1;
            end
        end
    end

    assign wdata0 = (mem_type_in & mem_addr_src_in) ? hi_word : lo_word;
    assign wdata1 = mem_addr_src_in ? lo_word : hi_word;

    always_comb begin
        dmem.addr   = '0;
        dmem.wdata  = '0;
        dmem.we     = 1'b0;
        dmem.re     = 1'b0;
        stall_out   = 1'b0;
        valid_out   = 1'b0;
        first_cycle = 1'b0;
        cur_rd      = 1'b0;
        cur_pop     = 1'b0;
        cur_pcpp    = 1'b0;
        cur_fpp     = 1'b0;
        // Gating with reset makes an abort take effect immediately, not at the next edge.
        if (!reset) begin
            dmem.we = 1'b0;
        end else if (state == SECOND) begin
            dmem.addr  = addr2_q;
            dmem.wdata = wdata2_q;
            dmem.we    = wr_q;
            dmem.re    = rd_q;
            valid_out  = 1'b1;
            cur_rd     = rd_q;
            cur_pop    = pop_q;
            cur_pcpp   = pcpp_q;
            cur_fpp    = fpp_q;
        end else if (access) begin
            dmem.addr   = addr0;
            dmem.wdata  = wdata0;
            dmem.we     = wr;
            dmem.re     = rd;
            stall_out   = mem_type_in;
            valid_out   = ~mem_type_in;
            first_cycle = 1'b1;
            cur_rd      = rd;
            cur_pop     = pop;
            cur_pcpp    = PC_push_pop_in;
            cur_fpp     = flags_push_pop_in;
        end
    end

    // Stack pops read the lower word first. Non-stack loads read the upper word at EA.
    always_comb begin
        loaded = '0;
        if (first_cycle)
            loaded = {16'h0000, dmem.rdata};
        else if (stack_q)
            loaded = {dmem.rdata, low_q};
        else
            loaded = {low_q, dmem.rdata};
    end

    assign done_rd           = valid_out & cur_rd;
    assign mem_data_out      = done_rd ? loaded : 32'h0;
    assign pop_pc_valid      = done_rd & cur_pop & cur_pcpp;
    assign pop_pc_out        = pop_pc_valid ? {4'h0, loaded[27:0]} : 32'h0;
    assign is_POP_flags_out  = done_rd & cur_pop & cur_fpp;
    assign POP_flags_val_out = is_POP_flags_out ? loaded[31:28] : 4'h0;
    assign SP_out            = sp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sp       <= SP_RESET;
            addr2_q  <= '0;
            wdata2_q <= '0;
            low_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            push_q   <= 1'b0;
            pop_q    <= 1'b0;
            stack_q  <= 1'b0;
            pcpp_q   <= 1'b0;
            fpp_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (mem_type_in) begin
                            state    <= SECOND;
                            addr2_q  <= addr1;
                            wdata2_q <= wdata1;
                            low_q    <= dmem.rdata;
                            rd_q     <= rd;
                            wr_q     <= wr;
                            push_q   <= push;
                            pop_q    <= pop;
                            stack_q  <= mem_addr_src_in;
                            pcpp_q   <= PC_push_pop_in;
                            fpp_q    <= flags_push_pop_in;
                        end else if (push) begin
                            sp <= sp - 1'b1;
                        end else if (pop) begin
                            sp <= sp + 1'b1;
                        end
                    end
                end
                SECOND: begin
                    state <= IDLE;
                    if (push_q)
                        sp <= sp - ADDR_W'(2);
                    else if (pop_q)
                        sp <= sp + ADDR_W'(2);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    localparam int AW = 12;

    logic        clk, reset, valid_in;
    logic [31:0] PC_in;
    logic [15:0] Rdst1_val_in, Rsrc_val_in, Rdst_val_in;
    logic        mem_read_in, mem_write_in, mem_type_in, mem_addr_src_in, mem_data_src_in;
    logic [1:0]  SP_src_in;
    logic        PC_push_pop_in, flags_push_pop_in;
    logic [31:0] mem_data_out, pop_pc_out;
    logic        pop_pc_valid, is_POP_flags_out, stall_out, valid_out;
    logic [3:0]  POP_flags_val_out;
    logic [AW-1:0] SP_out;

    mem_stage_if #(.ADDR_W(AW)) dmem ();

    mem_stage #(.ADDR_W(AW), .SP_RESET(12'hFFF)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .PC_in(PC_in),
        .Rdst1_val_in(Rdst1_val_in), .Rsrc_val_in(Rsrc_val_in), .Rdst_val_in(Rdst_val_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_type_in(mem_type_in),
        .mem_addr_src_in(mem_addr_src_in), .mem_data_src_in(mem_data_src_in),
        .SP_src_in(SP_src_in), .PC_push_pop_in(PC_push_pop_in),
        .flags_push_pop_in(flags_push_pop_in), .dmem(dmem),
        .mem_data_out(mem_data_out), .pop_pc_out(pop_pc_out), .pop_pc_valid(pop_pc_valid),
        .POP_flags_val_out(POP_flags_val_out), .is_POP_flags_out(is_POP_flags_out),
        .SP_out(SP_out), .stall_out(stall_out), .valid_out(valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory: unwritten words hold a fixed address-derived pattern.
    function automatic logic [15:0] init_val(input logic [11:0] a);
        return 16'h5555 + {4'h0, a};
    endfunction

    logic [15:0] sm   [4096];
    bit          sm_w [4096];
    assign dmem.rdata = sm_w[dmem.addr] ? sm[dmem.addr] : init_val(dmem.addr);
    always @(posedge clk) if (dmem.we) begin
        sm[dmem.addr]   <= dmem.wdata;
        sm_w[dmem.addr] <= 1'b1;
    end
    function automatic logic [15:0] mem_rd(input logic [11:0] a);
        return sm_w[a] ? sm[a] : init_val(a);
    endfunction

    typedef struct packed {
        logic valid, rd, wr, typ, asrc, dsrc;
        logic [1:0] sp_src;
        logic pcpp, fpp;
        logic [31:0] pc;
        logic [15:0] ea, rsrc, rdst;
    } instr_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] wdata;
        logic we, re, stall, valid;
        logic [31:0] data;
        logic pcv;
        logic [31:0] pc;
        logic fv;
        logic [3:0] fl;
        logic [11:0] sp;
    } exp_t;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    logic [15:0] mm [4096];
    logic [11:0] sp_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input logic v, r, w, t, as, ds, input logic [1:0] sps,
                                  input logic pcp, fp, input logic [31:0] pc,
                                  input logic [15:0] ea, rs, rdv);
        instr_t i;
        i.valid = v; i.rd = r; i.wr = w; i.typ = t; i.asrc = as; i.dsrc = ds;
        i.sp_src = sps; i.pcpp = pcp; i.fpp = fp; i.pc = pc; i.ea = ea; i.rsrc = rs; i.rdst = rdv;
        return i;
    endfunction

    // ---- behavioural model: a 32-bit value occupies two consecutive words ----
    function automatic logic is_acc(input instr_t in);
        return in.valid && (in.rd || in.wr);
    endfunction
    function automatic int n_words(input instr_t in);
        return (is_acc(in) && in.typ) ? 2 : 1;
    endfunction
    // Address of the k-th word touched by the access.
    function automatic logic [11:0] waddr(input instr_t in, input int k);
        if (!in.asrc) return in.ea[11:0] + 12'(k);
        if (in.sp_src == 2'd1) return sp_m - 12'(k);
        if (in.sp_src == 2'd2) return sp_m + 12'(1 + k);
        return sp_m + 12'(k);
    endfunction
    function automatic logic [15:0] wword(input instr_t in, input int k);
        logic [15:0] hi, lo;
        hi = in.dsrc ? in.pc[31:16] : in.rdst;
        lo = in.dsrc ? in.pc[15:0]  : in.rsrc;
        if (n_words(in) == 1) return lo;
        if (in.asrc) return (k == 0) ? hi : lo;
        return (k == 0) ? lo : hi;
    endfunction
    function automatic exp_t model_cycle(input instr_t in, input int k);
        exp_t e;
        logic r;
        logic [31:0] ld;
        int n;
        e = '0;
        n = n_words(in);
        r = in.rd && !in.wr;
        if (n == 1)      ld = {16'h0000, mm[waddr(in, 0)]};
        else if (in.asrc) ld = {mm[waddr(in, 1)], mm[waddr(in, 0)]};
        else             ld = {mm[waddr(in, 0)], mm[waddr(in, 1)]};
        e.sp = sp_m;
        if (is_acc(in)) begin
            e.addr  = waddr(in, k);
            e.wdata = wword(in, k);
            e.we    = in.wr;
            e.re    = r;
            e.stall = (n == 2) && (k == 0);
            e.valid = (k == n - 1);
            if (e.valid && r) begin
                e.data = ld;
                e.pcv  = (in.sp_src == 2'd2) && in.pcpp;
                e.pc   = {4'h0, ld[27:0]};
                e.fv   = (in.sp_src == 2'd2) && in.fpp;
                e.fl   = ld[31:28];
            end
        end
        return e;
    endfunction
    task automatic commit(input instr_t in);
        int n;
        n = n_words(in);
        if (is_acc(in)) begin
            if (in.wr) for (int k = 0; k < n; k++) mm[waddr(in, k)] = wword(in, k);
            if (in.sp_src == 2'd1) sp_m = sp_m - 12'(n);
            else if (in.sp_src == 2'd2) sp_m = sp_m + 12'(n);
        end
    endtask

    task automatic apply(input instr_t in);
        valid_in = in.valid; mem_read_in = in.rd; mem_write_in = in.wr; mem_type_in = in.typ;
        mem_addr_src_in = in.asrc; mem_data_src_in = in.dsrc; SP_src_in = in.sp_src;
        PC_push_pop_in = in.pcpp; flags_push_pop_in = in.fpp; PC_in = in.pc;
        Rdst1_val_in = in.ea; Rsrc_val_in = in.rsrc; Rdst_val_in = in.rdst;
    endtask

    // Called at posedge+1; holds the instruction for as many cycles as it takes.
    task automatic do_instr(input instr_t in);
        apply(in);
        for (int k = 0; k < n_words(in); k++) begin
            exp_q.push_back(model_cycle(in, k));
            @(posedge clk); #1;
        end
        commit(in);
        valid_in = 1'b0;
    endtask

    // Single compare process: every cycle with a pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("we", dmem.we, e.we);
                chk("re", dmem.re, e.re);
                chk("stall", stall_out, e.stall);
                chk("valid", valid_out, e.valid);
                chk("sp", SP_out, e.sp);
                chk("data", mem_data_out, e.data);
                chk("pc_valid", pop_pc_valid, e.pcv);
                chk("flags_valid", is_POP_flags_out, e.fv);
                if (e.we || e.re) chk("addr", dmem.addr, e.addr);
                if (e.we) chk("wdata", dmem.wdata, e.wdata);
                if (e.pcv) chk("pop_pc", pop_pc_out, e.pc);
                if (e.fv) chk("flags", POP_flags_val_out, e.fl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t t;
        exp_t e0, e1;
        for (int i = 0; i < 4096; i++) mm[i] = init_val(12'(i));
        sp_m = 12'hFFF;
        reset = 1'b0;
        apply(mk(0,0,0,0,0,0,2'd0,0,0,32'h0,16'h0,16'h0,16'h0));
        #12;
        chk("rst_sp", SP_out, 12'hFFF);
        chk("rst_stall", stall_out, 1'b0);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_we", dmem.we, 1'b0);
        chk("rst_data", mem_data_out, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        // 16-bit store
        t = mk(1,0,1,0,0,0,2'd0,0,0,32'h0,16'h0010,16'hBEEF,16'h0);
        e0 = model_cycle(t, 0);
        chk("pin_st_addr", e0.addr, 12'h010);
        chk("pin_st_wdata", e0.wdata, 16'hBEEF);
        do_instr(t);

        // 32-bit PC push
        t = mk(1,0,1,1,1,1,2'd1,0,0,32'hA0001234,16'h0,16'h0,16'h0);
        e0 = model_cycle(t, 0); e1 = model_cycle(t, 1);
        chk("pin_push_a0", e0.addr, 12'hFFF);
        chk("pin_push_w0", e0.wdata, 16'hA000);
        chk("pin_push_a1", e1.addr, 12'hFFE);
        chk("pin_push_w1", e1.wdata, 16'h1234);
        do_instr(t);
        chk("sp_after_push", SP_out, 12'hFFD);

        // 32-bit PC+flags pop
        t = mk(1,1,0,1,1,0,2'd2,1,1,32'h0,16'h0,16'h0,16'h0);
        e0 = model_cycle(t, 0); e1 = model_cycle(t, 1);
        chk("pin_pop_a0", e0.addr, 12'hFFE);
        chk("pin_pop_a1", e1.addr, 12'hFFF);
        chk("pin_pop_pc", e1.pc, 32'h00001234);
        chk("pin_pop_fl", e1.fl, 4'hA);
        do_instr(t);
        chk("sp_after_pop", SP_out, 12'hFFF);
        chk("pc_pulse_gone", pop_pc_valid, 1'b0);

        // no valid_in: nothing happens even for a 32-bit read
        do_instr(mk(0,1,0,1,1,0,2'd2,1,1,32'h0,16'h0,16'h0,16'h0));

        // read+write conflict acts as a write
        t = mk(1,1,1,0,0,0,2'd0,0,0,32'h0,16'h0020,16'h1111,16'h0);
        e0 = model_cycle(t, 0);
        chk("pin_conf_we", e0.we, 1'b1);
        chk("pin_conf_data", e0.data, 32'h0);
        do_instr(t);

        // 32-bit non-stack store then load
        do_instr(mk(1,0,1,1,0,0,2'd0,0,0,32'h0,16'h0100,16'h2222,16'h3333));
        t = mk(1,1,0,1,0,0,2'd0,0,0,32'h0,16'h0100,16'h0,16'h0);
        e1 = model_cycle(t, 1);
        chk("pin_ld32", e1.data, 32'h22223333);
        do_instr(t);

        // 16-bit load of the earlier store
        t = mk(1,1,0,0,0,0,2'd0,0,0,32'h0,16'h0010,16'h0,16'h0);
        e0 = model_cycle(t, 0);
        chk("pin_ld16", e0.data, 32'h0000BEEF);
        do_instr(t);

        // 16-bit pop wrapping SP from FFF to 000
        t = mk(1,1,0,0,1,0,2'd2,0,0,32'h0,16'h0,16'h0,16'h0);
        e0 = model_cycle(t, 0);
        chk("pin_pop16_addr", e0.addr, 12'h000);
        chk("pin_pop16_data", e0.data, 32'h00005555);
        do_instr(t);
        chk("sp_wrap_up", SP_out, 12'h000);

        // 16-bit push of PC low word wrapping SP back to FFF
        t = mk(1,0,1,0,1,1,2'd1,0,0,32'h0000ABCD,16'h0,16'h0,16'h0);
        e0 = model_cycle(t, 0);
        chk("pin_push16_w", e0.wdata, 16'hABCD);
        do_instr(t);
        chk("sp_wrap_down", SP_out, 12'hFFF);

        // reset during the second cycle of a 32-bit push
        t = mk(1,0,1,1,1,1,2'd1,0,0,32'hCAFE0042,16'h0,16'h0,16'h0);
        apply(t);
        exp_q.push_back(model_cycle(t, 0));
        @(posedge clk); #1;
        chk("mid_we_before", dmem.we, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("abort_stall", stall_out, 1'b0);
        chk("abort_we", dmem.we, 1'b0);
        chk("abort_valid", valid_out, 1'b0);
        chk("abort_sp", SP_out, 12'hFFF);
        valid_in = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        mm[12'hFFF] = 16'hCAFE;
        sp_m = 12'hFFF;
        chk("abort_no_2nd_write", mem_rd(12'hFFE), 16'h1234);
        chk("abort_1st_write", mem_rd(12'hFFF), 16'hCAFE);

        // normal operation after the abort
        do_instr(mk(1,0,1,0,0,0,2'd0,0,0,32'h0,16'h0030,16'h7777,16'h0));
        do_instr(mk(1,1,0,0,0,0,2'd0,0,0,32'h0,16'h0030,16'h0,16'h0));

        // 32-bit flags pop across the wrap: words 000 (ABCD) and 001 (untouched)
        t = mk(1,1,0,1,1,0,2'd2,0,1,32'h0,16'h0,16'h0,16'h0);
        e1 = model_cycle(t, 1);
        chk("pin_pop32_wrap", e1.data, 32'h5556ABCD);
        chk("pin_pop32_fl", e1.fl, 4'h5);
        do_instr(t);
        chk("sp_after_wrap_pop", SP_out, 12'h001);

        do_instr(mk(0,0,0,0,0,0,2'd0,0,0,32'h0,16'h0,16'h0,16'h0));
        @(posedge clk); #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
